// File: rtl/mcrb_fuse_seq.sv
// mcrb_fuse_seq: eFuse readout sequencer for the memory-controller repair block.
//
// Chooses between a power-on autoload request and a software reload request,
// then walks NUM_ENTRIES fuse entries. For each entry it issues one read strobe,
// waits RD_LAT cycles, captures the fuse word and writes it into the skew/repair
// register file. Only one eFuse read is ever outstanding.
//
// Ports:
//   mc_rb_ef1_sclk_i  block clock (rising edge)
//   gctl_rclk_orst_i  asynchronous active-high reset
//   por_load_req_i    power-on load request (level, served once per reset)
//   sw_reload_req_i   software reload request (pulse, merged while pending)
//   efuse_rd_o        eFuse read strobe, one cycle per entry
//   efuse_addr_o      eFuse read address (current entry index)
//   efuse_data_i      eFuse read data, valid RD_LAT cycles after the strobe
//   skew_wr_en_o      register-file write enable
//   skew_wr_addr_o    register-file write address (current entry index)
//   skew_wr_data_o    register-file write data (last captured fuse word)
//   busy_o            high while a sequence walks the entries
//   done_o            one-cycle pulse when a sequence completes
//   grant_src_o       source of the current/last grant: 0 = por, 1 = sw
//   load_cnt_o        completed sequences, saturating at 15

module mcrb_fuse_seq #(
    parameter int unsigned NUM_ENTRIES = 20,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned RD_LAT      = 3
) (
    input  logic              mc_rb_ef1_sclk_i,
    input  logic              gctl_rclk_orst_i,
    input  logic              por_load_req_i,
    input  logic              sw_reload_req_i,
    output logic              efuse_rd_o,
    output logic [ADDR_W-1:0] efuse_addr_o,
    input  logic [DATA_W-1:0] efuse_data_i,
    output logic              skew_wr_en_o,
    output logic [ADDR_W-1:0] skew_wr_addr_o,
    output logic [DATA_W-1:0] skew_wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              grant_src_o,
    output logic [3:0]        load_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StWrite,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_ENTRIES - 1);
    localparam logic [2:0]        RdLat   = 3'(RD_LAT);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [2:0]        wcnt_q;
    logic [DATA_W-1:0] data_q;
    logic              por_served_q;
    logic              sw_pend_q, sw_pend_d;
    logic              efuse_rd_q;
    logic              skew_wr_en_q;
    logic              busy_q;
    logic              done_q;
    logic              grant_src_q;
    logic [3:0]        load_cnt_q;
    logic              por_grant, sw_grant;

    // POR wins over SW; a new SW pulse coinciding with an SW grant stays pending.
    always_comb begin
        por_grant = (state_q == StIdle) && por_load_req_i && !por_served_q;
        sw_grant  = (state_q == StIdle) && !por_grant && sw_pend_q;
        sw_pend_d = (sw_pend_q && !sw_grant) || sw_reload_req_i;
    end

    // Outputs are registered alongside the state so each one is aligned with
    // the state it describes (e.g. efuse_rd_q is high exactly while in StIssue).
    always_ff @(posedge mc_rb_ef1_sclk_i or posedge gctl_rclk_orst_i) begin
        if (gctl_rclk_orst_i) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            wcnt_q       <= '0;
            data_q       <= '0;
            por_served_q <= 1'b0;
            sw_pend_q    <= 1'b0;
            efuse_rd_q   <= 1'b0;
            skew_wr_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            grant_src_q  <= 1'b0;
            load_cnt_q   <= '0;
        end else begin
            sw_pend_q    <= sw_pend_d;
            efuse_rd_q   <= 1'b0;
            skew_wr_en_q <= 1'b0;
            done_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (por_grant || sw_grant) begin
                        idx_q       <= '0;
                        grant_src_q <= sw_grant;
                        state_q     <= StIssue;
                        efuse_rd_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        if (por_grant) begin
                            por_served_q <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    wcnt_q  <= 3'd1;
                end
                StWait: begin
                    if (wcnt_q == RdLat) begin
                        data_q       <= efuse_data_i;
                        state_q      <= StWrite;
                        skew_wr_en_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + 3'd1;
                    end
                end
                StWrite: begin
                    if (idx_q == LastIdx) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (load_cnt_q != 4'hF) begin
                            load_cnt_q <= load_cnt_q + 4'd1;
                        end
                    end else begin
                        idx_q      <= idx_q + ADDR_W'(1);
                        state_q    <= StIssue;
                        efuse_rd_q <= 1'b1;
                    end
                end
                StDone: begin
                    // Addresses read as 0 while idle.
                    state_q <= StIdle;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign efuse_rd_o     = efuse_rd_q;
    assign efuse_addr_o   = idx_q;
    assign skew_wr_en_o   = skew_wr_en_q;
    assign skew_wr_addr_o = idx_q;
    assign skew_wr_data_o = data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign grant_src_o    = grant_src_q;
    assign load_cnt_o     = load_cnt_q;

endmodule
